// File: rtl/scroll_seq_ctrl_if.sv
// Key/switch inputs and display-side outputs of the scroll sequencer.
// The master drives the keys and switches; the slave is the sequencer.
interface scroll_seq_ctrl_if;
  logic       START;
  logic       STOP;
  logic       PAUSE;
  logic       STEP_BTN;
  logic       DIR;
  logic       LOOP;
  logic [3:0] STEP;
  logic       STEP_TICK;
  logic       BUSY;
  logic       DONE;
  logic [1:0] STATE;

  modport master (
    output START, STOP, PAUSE, STEP_BTN, DIR, LOOP,
    input  STEP, STEP_TICK, BUSY, DONE, STATE
  );

  modport slave (
    input  START, STOP, PAUSE, STEP_BTN, DIR, LOOP,
    output STEP, STEP_TICK, BUSY, DONE, STATE
  );
endinterface

// File: rtl/scroll_seq_ctrl.sv
// Timed frame sequencer for the "HAPPY" scrolling display decoder.
// Walks STEP through frames 0..LAST (or LAST..0) once per DIV clocks,
// with start/stop/pause/single-step key pulses and loop/direction levels.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | stopped, STEP=0, waiting for START
// RUN    | prescaler counting, advance each time it wraps
// PAUSE  | prescaler frozen, STEP_BTN advances one frame
// FINISH | end frame reached without loop, STEP held, DONE=1
module scroll_seq_ctrl #(
  parameter int DIV   = 50000000,
  parameter int DIV_W = 26,
  parameter int LAST  = 9
) (
  input  logic               CLOCK_50,
  input  logic               RST_N,
  scroll_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [3:0]       LAST_V    = 4'(LAST);
  localparam logic [DIV_W-1:0] PRESC_END = DIV_W'(DIV - 1);

  state_t           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]       adv_step;
  logic             adv_finish;
  logic             take_adv;
  logic [3:0]       start_frame;

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      step_q  <= 4'd0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Frame that one advance would produce, with explicit end-of-range checks.
  always_comb begin
    adv_step   = step_q;
    adv_finish = 1'b0;
    if (!bus.DIR) begin
      if (step_q < LAST_V)  adv_step = step_q + 4'd1;
      else if (bus.LOOP)    adv_step = 4'd0;
      else                  adv_finish = 1'b1;
    end else begin
      if (step_q != 4'd0)   adv_step = step_q - 4'd1;
      else if (bus.LOOP)    adv_step = LAST_V;
      else                  adv_finish = 1'b1;
    end
  end

  // Next-state logic: STOP > START > PAUSE > STEP_BTN > prescaler tick.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    presc_d     = presc_q;
    tick_d      = 1'b0;
    take_adv    = 1'b0;
    start_frame = bus.DIR ? LAST_V : 4'd0;

    if (bus.STOP) begin
      state_d = S_IDLE;
      step_d  = 4'd0;
      presc_d = '0;
    end else if (bus.START) begin
      state_d = S_RUN;
      step_d  = start_frame;
      presc_d = '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          // A pause in the wrap cycle keeps the prescaler at its end value,
          // so the suppressed advance fires on the first cycle after resume.
          if (bus.PAUSE) begin
            state_d = S_PAUSE;
          end else if (presc_q == PRESC_END) begin
            presc_d  = '0;
            take_adv = 1'b1;
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
        S_PAUSE: begin
          if (bus.PAUSE)         state_d  = S_RUN;
          else if (bus.STEP_BTN) take_adv = 1'b1;
        end
        default: ;
      endcase

      if (take_adv) begin
        if (adv_finish) begin
          state_d = S_FINISH;
        end else begin
          step_d = adv_step;
          tick_d = 1'b1;
        end
      end
    end
  end

  // Status flags follow the next state so they register alongside it.
  always_comb begin
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
    done_d = (state_d == S_FINISH);
  end

  assign bus.STEP      = step_q;
  assign bus.STEP_TICK = tick_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.STATE     = state_q;

endmodule

// File: tb/tb_scroll_seq_ctrl.sv
// Bench for scroll_seq_ctrl: directed scenarios with literal expectations,
// then random key traffic, all checked every cycle against a frame model.
module tb_scroll_seq_ctrl;
  localparam int DIV  = 4;
  localparam int LAST = 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  scroll_seq_ctrl_if bus ();

  scroll_seq_ctrl #(.DIV(DIV), .DIV_W(3), .LAST(LAST)) dut (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: mode uses the STATE encoding (0 idle,1 run,2 pause,3 finish),
  // elapsed counts run cycles since the last advance or start.
  int m_mode    = 0;
  int m_step    = 0;
  int m_elapsed = 0;
  bit m_tick    = 0;

  always @(posedge clk or negedge rst_n) begin
    int  mode, step, elapsed, nxt;
    bit  tick, adv;
    if (!rst_n) begin
      m_mode <= 0; m_step <= 0; m_elapsed <= 0; m_tick <= 0;
    end else begin
      mode = m_mode; step = m_step; elapsed = m_elapsed;
      tick = 0; adv = 0;
      if (bus.STOP) begin
        mode = 0; step = 0; elapsed = 0;
      end else if (bus.START) begin
        mode = 1; step = bus.DIR ? LAST : 0; elapsed = 0;
      end else if (mode == 1) begin
        if (bus.PAUSE) mode = 2;
        else begin
          elapsed = elapsed + 1;
          if (elapsed == DIV) begin elapsed = 0; adv = 1; end
        end
      end else if (mode == 2) begin
        if (bus.PAUSE) mode = 1;
        else if (bus.STEP_BTN) adv = 1;
      end
      if (adv) begin
        nxt = bus.DIR ? step - 1 : step + 1;
        if (nxt < 0 || nxt > LAST) begin
          if (bus.LOOP) begin step = bus.DIR ? LAST : 0; tick = 1; end
          else mode = 3;
        end else begin
          step = nxt; tick = 1;
        end
      end
      m_mode <= mode; m_step <= step; m_elapsed <= elapsed; m_tick <= tick;
    end
  end

  // Every-cycle compare on the falling edge.
  always @(negedge clk) begin
    logic [8:0] act, exp;
    act = {bus.STATE, bus.STEP, bus.STEP_TICK, bus.BUSY, bus.DONE};
    exp = {2'(m_mode), 4'(m_step), m_tick, (m_mode == 1 || m_mode == 2), (m_mode == 3)};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t got state/step/tick/busy/done=%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
               $time, act[8:7], act[6:3], act[2], act[1], act[0],
               exp[8:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit st, input bit sp, input bit pa, input bit sb);
    bus.START = st; bus.STOP = sp; bus.PAUSE = pa; bus.STEP_BTN = sb;
    @(negedge clk);
    bus.START = 0; bus.STOP = 0; bus.PAUSE = 0; bus.STEP_BTN = 0;
  endtask

  initial begin
    bus.START = 0; bus.STOP = 0; bus.PAUSE = 0; bus.STEP_BTN = 0;
    bus.DIR = 0; bus.LOOP = 0;
    idle(3);
    check("reset_state", bus.STATE, 0);
    check("reset_step", bus.STEP, 0);
    rst_n = 1'b1;
    idle(2);

    // Forward, no loop
    pulse(1, 0, 0, 0);
    check("fwd_start_step", bus.STEP, 0);
    check("fwd_start_state", bus.STATE, 1);
    idle(3);
    check("fwd_hold_before_first", bus.STEP, 0);
    idle(1);
    check("fwd_first_adv", bus.STEP, 1);
    check("fwd_first_tick", bus.STEP_TICK, 1);
    idle(32);
    check("fwd_reach_last", bus.STEP, 9);
    idle(4);
    check("fwd_finish_state", bus.STATE, 3);
    check("fwd_finish_done", bus.DONE, 1);
    check("fwd_finish_step", bus.STEP, 9);
    check("fwd_finish_no_tick", bus.STEP_TICK, 0);

    // Restart out of FINISH
    pulse(1, 0, 0, 0);
    check("restart_state", bus.STATE, 1);
    check("restart_step", bus.STEP, 0);
    check("restart_done", bus.DONE, 0);

    // Pause and single-step
    idle(12);
    check("pause_pre_step", bus.STEP, 3);
    idle(1);
    pulse(0, 0, 1, 0);
    check("pause_state", bus.STATE, 2);
    idle(20);
    check("pause_frozen_step", bus.STEP, 3);
    check("pause_frozen_state", bus.STATE, 2);
    pulse(0, 0, 0, 1);
    check("single_step_1", bus.STEP, 4);
    check("single_step_1_tick", bus.STEP_TICK, 1);
    pulse(0, 0, 0, 1);
    check("single_step_2", bus.STEP, 5);
    pulse(0, 0, 1, 0);
    check("resume_state", bus.STATE, 1);
    idle(2);
    check("resume_hold", bus.STEP, 5);
    idle(1);
    check("resume_adv", bus.STEP, 6);

    // Priority
    pulse(1, 1, 0, 0);
    check("stop_beats_start_state", bus.STATE, 0);
    check("stop_beats_start_step", bus.STEP, 0);
    pulse(1, 0, 0, 0);
    idle(3);
    pulse(0, 0, 1, 0);
    check("pause_on_wrap_state", bus.STATE, 2);
    check("pause_on_wrap_step", bus.STEP, 0);
    pulse(0, 0, 1, 0);
    idle(1);
    check("pause_on_wrap_resume_adv", bus.STEP, 1);

    // Reverse with loop
    bus.DIR = 1; bus.LOOP = 1;
    pulse(1, 0, 0, 0);
    check("rev_start_step", bus.STEP, 9);
    idle(36);
    check("rev_reach_zero", bus.STEP, 0);
    idle(4);
    check("rev_wrap_step", bus.STEP, 9);
    check("rev_wrap_tick", bus.STEP_TICK, 1);
    idle(4);
    check("rev_after_wrap", bus.STEP, 8);
    check("rev_busy", bus.BUSY, 1);
    check("rev_not_done", bus.DONE, 0);

    // Asynchronous reset mid-run at STEP=5
    bus.DIR = 0; bus.LOOP = 0;
    pulse(1, 0, 0, 0);
    idle(20);
    check("pre_reset_step", bus.STEP, 5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_step", bus.STEP, 0);
    check("async_rst_state", bus.STATE, 0);
    check("async_rst_flags", {bus.STEP_TICK, bus.BUSY, bus.DONE}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Random key traffic
    for (int i = 0; i < 3000; i++) begin
      bus.START    = ($urandom_range(39) == 0);
      bus.STOP     = ($urandom_range(149) == 0);
      bus.PAUSE    = ($urandom_range(14) == 0);
      bus.STEP_BTN = ($urandom_range(5) == 0);
      if ($urandom_range(49) == 0) bus.DIR  = ~bus.DIR;
      if ($urandom_range(59) == 0) bus.LOOP = ~bus.LOOP;
      @(negedge clk);
    end
    bus.START = 0; bus.STOP = 0; bus.PAUSE = 0; bus.STEP_BTN = 0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
